// File: rtl/bpsk_demodulator.sv
// Coherent BPSK demodulator: square-wave correlation over SPS samples, one bit per symbol, MSB-first word assembly.
// Optional erasure flag for weak correlations is enabled by defining BPSK_DEMOD_ERASE_EN.
//
// state  | meaning
// IDLE   | waiting for a Flag-marked sample to start a symbol
// ACCUM  | correlating samples at phase 1..SPS-1
// DECIDE | one-cycle slot after the last sample; bit_valid is high
module bpsk_demodulator #(
  parameter int WIDTH     = 7,
  parameter int SPS       = 8,
  parameter int WORD      = 8,
  parameter int ERASE_THR = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  input  logic             Flag,
  output logic             bit_out,
  output logic             bit_valid,
  output logic [WORD-1:0]  word_out,
  output logic             word_valid,
  output logic             sync_lost
`ifdef BPSK_DEMOD_ERASE_EN
  ,
  output logic             erase
`endif
);

  localparam int PW   = $clog2(SPS);
  localparam int ACCW = WIDTH + PW + 1;
  localparam int CW   = $clog2(WORD) + 1;

  if ((SPS < 4) || ((SPS & (SPS - 1)) != 0) || (ERASE_THR < 0)) begin : g_bad_param
    $error("bpsk_demodulator: SPS must be a power of two >= 4 and ERASE_THR non-negative");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, DECIDE} state_t;

  state_t                 state_q, state_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [ACCW-1:0] samp_ext, acc_sum;
  logic [PW-1:0]          phase_q, phase_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WORD-1:0]        sr_q, sr_d, word_q, word_d;
  logic                   bit_q, bit_d, bv_q, bv_d, wv_q, wv_d, sl_q, sl_d;
  logic                   start, dec_bit;

  assign start    = sample_valid && Flag;
  assign samp_ext = {{(ACCW-WIDTH){sample_in[WIDTH-1]}}, sample_in};
  // MSB of phase selects the negative half of the reference square wave
  assign acc_sum  = phase_q[PW-1] ? (acc_q - samp_ext) : (acc_q + samp_ext);
  assign dec_bit  = acc_sum[ACCW-1];

`ifdef BPSK_DEMOD_ERASE_EN
  logic signed [ACCW-1:0] acc_mag;
  logic                   er_q, er_d;
  assign acc_mag = acc_sum[ACCW-1] ? -acc_sum : acc_sum;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    word_d  = word_q;
    bit_d   = bit_q;
    bv_d    = 1'b0;
    wv_d    = 1'b0;
    sl_d    = 1'b0;
`ifdef BPSK_DEMOD_ERASE_EN
    er_d    = er_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = samp_ext;
          phase_d = PW'(1);
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (start) begin
          acc_d   = samp_ext;
          phase_d = PW'(1);
          sl_d    = 1'b1;
          cnt_d   = '0;
        end else if (sample_valid) begin
          acc_d = acc_sum;
          if (phase_q == PW'(SPS - 1)) begin
            // decision is registered on the last sample's edge so bit_valid lands in DECIDE
            state_d = DECIDE;
            phase_d = '0;
            bit_d   = dec_bit;
            bv_d    = 1'b1;
            sr_d    = WORD'({sr_q, dec_bit});
`ifdef BPSK_DEMOD_ERASE_EN
            er_d    = (acc_mag < ACCW'(ERASE_THR));
`endif
            if (cnt_q == CW'(WORD - 1)) begin
              cnt_d  = '0;
              word_d = WORD'({sr_q, dec_bit});
              wv_d   = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
      end
      DECIDE: begin
        // single-cycle slot: a Flag sample chains the next symbol, anything else falls back to IDLE
        if (start) begin
          acc_d   = samp_ext;
          phase_d = PW'(1);
          state_d = ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      acc_q   <= '0;
      phase_q <= '0;
      cnt_q   <= '0;
      sr_q    <= '0;
      word_q  <= '0;
      bit_q   <= 1'b0;
      bv_q    <= 1'b0;
      wv_q    <= 1'b0;
      sl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      word_q  <= word_d;
      bit_q   <= bit_d;
      bv_q    <= bv_d;
      wv_q    <= wv_d;
      sl_q    <= sl_d;
    end
  end

`ifdef BPSK_DEMOD_ERASE_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) er_q <= 1'b0;
    else        er_q <= er_d;
  end
  assign erase = er_q;
`endif

  assign bit_out    = bit_q;
  assign bit_valid  = bv_q;
  assign word_out   = word_q;
  assign word_valid = wv_q;
  assign sync_lost  = sl_q;

endmodule
